qspi_mem_responder: RTL and testbench

- Memory-side responder for the dual-I/O serial memory protocol issued by the SoC's SPI/QSPI flash/PSRAM master.
- Used as a synthesizable PSRAM/flash stand-in on FPGA builds and as the far-end model in SoC benches.
- Oversamples the SPI pins on the system clock, decodes command 0xBB (read) and 0x38 (write), and moves bytes over a simple byte-wide memory port.
- Supports sequential streaming with auto-incrementing address until chip select deasserts.

---
 rtl/qspi_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_qspi_mem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_responder.sv
// Dual-I/O serial memory responder: oversamples SPI pins on clk, decodes 0xBB read / 0x38 write,
// and streams bytes through a single-outstanding byte-wide memory port with auto-increment.
`timescale 1ns/1ps
module qspi_mem_responder #(
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter logic [23:0] ADDR_MASK    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic [3:0]  spi_io_in,
  output logic [3:0]  spi_io_out,
  output logic [3:0]  spi_io_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [7:0]  CMD_READ   = 8'hBB;
  localparam logic [7:0]  CMD_WRITE  = 8'h38;
  localparam int unsigned DW         = (DUMMY_CYCLES < 2) ? 1 : $clog2(DUMMY_CYCLES + 1);
  localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t        state;
  logic [1:0]    sck_sync, cs_sync, io_meta, io_sync;
  logic          sck_q;
  logic [23:0]   addr;
  logic [7:0]    shreg, pf_byte;
  logic [3:0]    bit_cnt;
  logic [1:0]    pair_cnt;
  logic [DW-1:0] dummy_cnt;
  logic          is_read, pf_valid, underrun;

  logic          sck_rise, sck_fall, cs_high;
  logic [7:0]    cmd_byte, wr_byte;
  logic [23:0]   addr_full, addr_next;
  logic          unused_io;

  assign sck_rise  = sck_sync[1] & ~sck_q;
  assign sck_fall  = ~sck_sync[1] & sck_q;
  assign cs_high   = cs_sync[1];
  assign cmd_byte  = {shreg[6:0], io_sync[0]};
  assign wr_byte   = {shreg[5:0], io_sync};
  assign addr_full = {addr[21:0], io_sync};
  assign addr_next = (addr + 24'd1) & ADDR_MASK;
  assign unused_io = ^spi_io_in[3:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sck_sync   <= '0;
      cs_sync    <= '1;
      io_meta    <= '0;
      io_sync    <= '0;
      sck_q      <= 1'b0;
      addr       <= '0;
      shreg      <= '0;
      pf_byte    <= '0;
      bit_cnt    <= '0;
      pair_cnt   <= '0;
      dummy_cnt  <= '0;
      is_read    <= 1'b0;
      pf_valid   <= 1'b0;
      underrun   <= 1'b0;
      spi_io_out <= '0;
      spi_io_oe  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], spi_clk};
      cs_sync  <= {cs_sync[0], spi_cs_n};
      io_meta  <= spi_io_in[1:0];
      io_sync  <= io_meta;
      sck_q    <= sck_sync[1];
      cmd_err  <= 1'b0;

      // The handshake always completes; read data is kept only while this read frame is live.
      if (mem_req && mem_ready) begin
        mem_req <= 1'b0;
        if (!mem_we && !cs_high && (state == S_DUMMY || state == S_RDATA)) begin
          pf_byte  <= mem_rdata;
          pf_valid <= 1'b1;
        end
      end

      if (cs_high) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        spi_io_oe  <= '0;
        spi_io_out <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_CMD;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            pair_cnt  <= '0;
            dummy_cnt <= '0;
            pf_valid  <= 1'b0;
            underrun  <= 1'b0;
          end
          S_CMD: if (sck_rise) begin
            shreg   <= cmd_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (cmd_byte == CMD_READ) begin
                state   <= S_ADDR;
                is_read <= 1'b1;
              end else if (cmd_byte == CMD_WRITE) begin
                state   <= S_ADDR;
                is_read <= 1'b0;
              end else begin
                state   <= S_IGNORE;
                cmd_err <= 1'b1;
              end
            end
          end
          S_ADDR: if (sck_rise) begin
            addr    <= addr_full;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd11) begin
              bit_cnt <= '0;
              if (is_read) begin
                addr <= addr_full & ADDR_MASK;
                if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= addr_full & ADDR_MASK;
                end
                state <= (DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_DUMMY: if (sck_rise) begin
            dummy_cnt <= dummy_cnt + 1'b1;
            if (dummy_cnt == DUMMY_LAST) state <= S_RDATA;
          end
          S_RDATA: if (sck_fall) begin
            spi_io_oe <= 4'b0011;
            pair_cnt  <= pair_cnt + 2'd1;
            if (pair_cnt == 2'd0) begin
              if (pf_valid && !underrun) begin
                spi_io_out <= {2'b00, pf_byte[7:6]};
                shreg      <= {pf_byte[5:0], 2'b00};
                pf_valid   <= 1'b0;
                if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= addr_next;
                end
              end else begin
                underrun   <= 1'b1;
                spi_io_out <= '0;
                shreg      <= '0;
              end
            end else begin
              spi_io_out <= {2'b00, shreg[7:6]};
              shreg      <= {shreg[5:0], 2'b00};
            end
            if (pair_cnt == 2'd3) addr <= addr_next;
          end
          S_WDATA: if (sck_rise) begin
            shreg   <= wr_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd3) begin
              bit_cnt <= '0;
              addr    <= addr_next;
              if (!mem_req) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_wdata <= wr_byte;
                mem_addr  <= addr & ADDR_MASK;
              end
            end
          end
          S_IGNORE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Scoreboarded bench for qspi_mem_responder: expected memory requests are queued as frames are
// driven and checked as the responder issues them; read streams are checked pair by pair.
`timescale 1ns/1ps
module tb_qspi_mem_responder;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk;
  logic        spi_cs_n;
  logic [3:0]  spi_io_in;
  logic [3:0]  spi_io_out;
  logic [3:0]  spi_io_oe;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        cmd_err;

  qspi_mem_responder #(.DUMMY_CYCLES(4), .ADDR_MASK(24'h0003FF)) u_dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_io_in(spi_io_in), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t       exp_q[$];
  logic [7:0] mem_arr [0:1023];
  int n_checks = 0, n_pass = 0;
  int req_seen = 0, cmd_err_cycles = 0, oe_hi_cycles = 0;
  bit pending = 0;
  int wait_cnt = 0;

  // Memory model with random latency; each new request is popped from the scoreboard.
  always @(negedge clk) begin
    req_t e;
    mem_ready = 1'b0;
    if (cmd_err) cmd_err_cycles++;
    if (spi_io_oe != 4'b0000) oe_hi_cycles++;
    if (!rst_n) begin
      pending = 0;
    end else if (mem_req) begin
      if (!pending) begin
        pending  = 1;
        wait_cnt = $urandom_range(1, 6);
        req_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL mem_req_unexpected got we=%0b addr=%h wdata=%h want no request",
                   mem_we, mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)} !== {e.we, e.addr, e.data})
            $display("FAIL mem_req got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
          else n_pass++;
        end
      end else if (wait_cnt == 0) begin
        if (mem_we) mem_arr[mem_addr[9:0]] = mem_wdata;
        else        mem_rdata = mem_arr[mem_addr[9:0]];
        mem_ready = 1'b1;
        pending   = 0;
      end else begin
        wait_cnt--;
      end
    end
  end

  task automatic push_req(input logic we, input logic [23:0] a, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = a; r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic sck_cycle(input logic [1:0] io);
    spi_io_in = {2'b00, io};
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic sck_read(output logic [1:0] io, output logic [3:0] oe);
    spi_io_in = 4'b0000;
    repeat (HALF) @(negedge clk);
    io = spi_io_out[1:0];
    oe = spi_io_oe;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) sck_cycle({1'b0, c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 11; i >= 0; i--) sck_cycle(a[2*i +: 2]);
  endtask

  task automatic send_byte2(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) sck_cycle(b[2*i +: 2]);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({spi_io_out, spi_io_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, cmd_err} !== 46'd0)
      $display("FAIL reset_outputs got out=%h oe=%h req=%b addr=%h busy=%b want all 0",
               spi_io_out, spi_io_oe, mem_req, mem_addr, busy);
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy, spi_io_oe, mem_req} !== 6'd0)
      $display("FAIL reset_release got busy=%b oe=%h req=%b want 0", busy, spi_io_oe, mem_req);
    else n_pass++;
  endtask

  task automatic test_read();
    logic [7:0] exp_bytes [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h96};
    logic [1:0] io, want;
    logic [3:0] oe;
    for (int a = 'h100; a <= 'h104; a++) push_req(1'b0, 24'(a), 8'h00);
    cs_low();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL read_busy got %b want 1", busy);
    else n_pass++;
    send_cmd(8'hBB);
    send_addr(24'h000100);
    for (int d = 0; d < 4; d++) begin
      sck_read(io, oe);
      n_checks++;
      if (oe !== 4'b0000) $display("FAIL read_dummy_oe[%0d] got %b want 0000", d, oe);
      else n_pass++;
    end
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 4; p++) begin
        sck_read(io, oe);
        want = exp_bytes[b][7-2*p -: 2];
        n_checks++;
        if ({oe, io} !== {4'b0011, want})
          $display("FAIL read_pair[%0d.%0d] got oe=%b io=%b want oe=0011 io=%b", b, p, oe, io, want);
        else n_pass++;
      end
    end
    cs_high();
    n_checks++;
    if ({busy, spi_io_oe} !== 5'd0) $display("FAIL read_end got busy=%b oe=%b want 0", busy, spi_io_oe);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL read_reqs got %0d outstanding want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_write();
    push_req(1'b1, 24'h0000FE, 8'h11);
    push_req(1'b1, 24'h0000FF, 8'h22);
    push_req(1'b1, 24'h000100, 8'h33);
    cs_low();
    send_cmd(8'h38);
    send_addr(24'h0000FE);
    send_byte2(8'h11);
    send_byte2(8'h22);
    send_byte2(8'h33);
    cs_high();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL write_reqs got %0d outstanding want 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (spi_io_oe !== 4'b0000) $display("FAIL write_oe got %b want 0000", spi_io_oe);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_bytes [2] = '{8'h5A, 8'hC3};
    logic [1:0] io, want;
    logic [3:0] oe;
    push_req(1'b0, 24'h0003FF, 8'h00);
    push_req(1'b0, 24'h000000, 8'h00);
    push_req(1'b0, 24'h000001, 8'h00);
    cs_low();
    send_cmd(8'hBB);
    send_addr(24'h7FF3FF);
    for (int d = 0; d < 4; d++) sck_cycle(2'b00);
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 4; p++) begin
        sck_read(io, oe);
        want = exp_bytes[b][7-2*p -: 2];
        n_checks++;
        if ({oe, io} !== {4'b0011, want})
          $display("FAIL wrap_pair[%0d.%0d] got oe=%b io=%b want oe=0011 io=%b", b, p, oe, io, want);
        else n_pass++;
      end
    end
    cs_high();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL wrap_reqs got %0d outstanding want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bad_cmd();
    int req0;
    logic [1:0] io;
    logic [3:0] oe;
    req0 = req_seen;
    cmd_err_cycles = 0;
    oe_hi_cycles = 0;
    cs_low();
    send_cmd(8'h03);
    for (int i = 0; i < 16; i++) sck_read(io, oe);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL badcmd_busy got %b want 1", busy);
    else n_pass++;
    cs_high();
    n_checks++;
    if (cmd_err_cycles != 1) $display("FAIL badcmd_err_pulse got %0d cycles want 1", cmd_err_cycles);
    else n_pass++;
    n_checks++;
    if (req_seen != req0) $display("FAIL badcmd_reqs got %0d want %0d", req_seen, req0);
    else n_pass++;
    n_checks++;
    if (oe_hi_cycles != 0) $display("FAIL badcmd_oe got %0d driven cycles want 0", oe_hi_cycles);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    logic [1:0] io, want;
    logic [3:0] oe;
    logic [7:0] b0 = 8'h33;
    int req0;
    req0 = req_seen;
    cs_low();
    send_cmd(8'h38);
    send_addr(24'h000200);
    sck_cycle(2'b10);
    sck_cycle(2'b01);
    sck_cycle(2'b11);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, spi_io_oe} !== 5'd0) $display("FAIL partial_cs got busy=%b oe=%b want 0", busy, spi_io_oe);
    else n_pass++;
    repeat (8) @(negedge clk);
    n_checks++;
    if (req_seen != req0) $display("FAIL partial_reqs got %0d want %0d", req_seen, req0);
    else n_pass++;
    push_req(1'b0, 24'h000100, 8'h00);
    push_req(1'b0, 24'h000101, 8'h00);
    cs_low();
    send_cmd(8'hBB);
    send_addr(24'h000100);
    for (int d = 0; d < 4; d++) sck_cycle(2'b00);
    for (int p = 0; p < 4; p++) begin
      sck_read(io, oe);
      want = b0[7-2*p -: 2];
      n_checks++;
      if ({oe, io} !== {4'b0011, want})
        $display("FAIL partial_next_pair[%0d] got oe=%b io=%b want oe=0011 io=%b", p, oe, io, want);
      else n_pass++;
    end
    cs_high();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL partial_next_reqs got %0d outstanding want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] io;
    logic [3:0] oe;
    push_req(1'b0, 24'h000100, 8'h00);
    push_req(1'b0, 24'h000101, 8'h00);
    cs_low();
    send_cmd(8'hBB);
    send_addr(24'h000100);
    for (int d = 0; d < 4; d++) sck_cycle(2'b00);
    sck_read(io, oe);
    sck_read(io, oe);
    n_checks++;
    if (spi_io_oe !== 4'b0011) $display("FAIL midrst_pre_oe got %b want 0011", spi_io_oe);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spi_io_out, spi_io_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, cmd_err} !== 46'd0)
      $display("FAIL midrst_outputs got out=%h oe=%h req=%b addr=%h busy=%b want all 0",
               spi_io_out, spi_io_oe, mem_req, mem_addr, busy);
    else n_pass++;
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({busy, spi_io_oe, mem_req} !== 6'd0)
      $display("FAIL midrst_idle got busy=%b oe=%b req=%b want 0", busy, spi_io_oe, mem_req);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL midrst_reqs got %0d outstanding want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 8'(i) ^ 8'h5C;
    mem_arr['h100] = 8'hA5;
    mem_arr['h101] = 8'h3C;
    mem_arr['h102] = 8'hF0;
    mem_arr['h103] = 8'h96;
    mem_arr['h3FF] = 8'h5A;
    mem_arr['h000] = 8'hC3;
    rst_n     = 1'b0;
    spi_clk   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_io_in = 4'b0000;
    repeat (3) @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_bad_cmd();
    test_partial_write();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
